dot_product_engine: RTL and testbench
=====================================

# dot_product_engine

Streaming multiply-accumulate stage that feeds the memory writer. It pops VEC_LEN signed element pairs from two operand FIFOs and accumulates their products at full precision. It then saturates the sum to RESULT_WIDTH and presents it on `dot_product_result` with a one-cycle `result_valid` strobe. The strobe drives the writer's `start_writing`, and the result drives its `dot_product_result`.

## Interface
- DATA_WIDTH, 16, signed element width of each operand FIFO
- VEC_LEN, 4, elements per dot product (>= 1)
- RESULT_WIDTH, 16, signed output width (<= ACC_WIDTH)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(VEC_LEN)+1, internal accumulator width (localparam, not overridable)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin one dot product; sampled only in IDLE
- fifo_a_empty  in  1  operand A FIFO empty flag
- fifo_a_dout  in  DATA_WIDTH  operand A read data, valid the cycle after `fifo_a_rd_en`
- fifo_a_rd_en  out  1  pop operand A
- fifo_b_empty  in  1  operand B FIFO empty flag
- fifo_b_dout  in  DATA_WIDTH  operand B read data, valid the cycle after `fifo_b_rd_en`
- fifo_b_rd_en  out  1  pop operand B
- busy  out  1  high whenever state != IDLE
- dot_product_result  out  RESULT_WIDTH  saturated signed result, held until next result
- result_valid  out  1  one-cycle strobe when `dot_product_result` updates

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: issue reads and accumulate.
- Transitions:
  - IDLE -> RUN on `start`. Accumulator, issue counter and accumulate counter are cleared on that edge.
  - RUN -> IDLE on the edge where the VEC_LEN-th product is accumulated.
- Read issue (combinational): `fifo_a_rd_en` = `fifo_b_rd_en` = (state==RUN) && !fifo_a_empty && !fifo_b_empty && (issued < VEC_LEN).
  - Both FIFOs always pop together and never individually.
  - The engine never reads an empty FIFO.
- Data-valid flag: a registered flag marks the cycle after a pop. In that cycle, product = signed(fifo_a_dout) * signed(fifo_b_dout), 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
  - acc <= acc + product.
  - The accumulated-element counter increments.
- Issue pipelining: issue and accumulate overlap, so back-to-back pops are allowed every cycle.
- Last element: on the edge where the last element is accumulated:
  - `dot_product_result` <= sat(acc + product).
  - `result_valid` <= 1.
  - state <= IDLE.
- Saturation to RESULT_WIDTH signed:
  - If > 2^(RESULT_WIDTH-1)-1, clamp to max.
  - If < -2^(RESULT_WIDTH-1), clamp to min.
  - Otherwise truncate to the low RESULT_WIDTH bits, which is lossless.
- Counters: wide enough for VEC_LEN inclusive and never wrap within one vector.
- `start` while busy: ignored, not queued.
- `start` in the same cycle `result_valid` is high: state is already IDLE, so it is accepted.
- Reset mid-operation: return to IDLE and clear accumulator, counters and data-valid flag. An element popped in the reset cycle is discarded. Upstream must re-prime the FIFOs.

## Timing
- Reset values:
  - `fifo_a_rd_en` = 0, `fifo_b_rd_en` = 0
  - `busy` = 0
  - `dot_product_result` = 0
  - `result_valid` = 0
  - state IDLE
- No stalls, `start` in cycle 0:
  - `busy` high from cycle 1.
  - Pops in cycles 1..VEC_LEN.
  - `result_valid` high in cycle VEC_LEN+2.
  - `busy` low in cycle VEC_LEN+2.
  - Total latency is VEC_LEN+2 cycles.
- Stalls: each cycle with either FIFO empty (while reads remain) delays `result_valid` by one cycle. Partial accumulation is preserved across stalls.
- `result_valid`: exactly one cycle wide.
- `dot_product_result`: changes only on the edge that raises `result_valid`.
- Back-to-back throughput: VEC_LEN+2 cycles per result when `start` is re-asserted in the `result_valid` cycle.

## Test plan
- Basic, VEC_LEN=4: A=[1,2,3,4], B=[5,6,7,8], pulse `start`.
  - Required: `result_valid` pulses once at cycle 6 with result 70.
  - Required: exactly 4 pops on each FIFO.
- Signed values: A=[-3,2,-1,4], B=[5,-6,7,8].
  - Required: result 16'hFFFE (-2).
- Positive saturation: A=B=[32767]x4.
  - Required: result 16'h7FFF.
- Negative saturation: A=[32767]x4, B=[-32768]x4.
  - Required: result 16'h8000.
- Stall: B empty for 3 cycles after the 2nd pop, data [1,2,3,4]·[5,6,7,8].
  - Required: rd_en low on both FIFOs during the stall.
  - Required: result 70 with `result_valid` at cycle 9.
- Control corner cases:
  - Reset asserted at cycle 3 of a run: outputs return to reset values. A fresh run with 4 new elements then yields the correct result.
  - `start` pulsed while busy: ignored, and only one result is produced.
  - `start` in the `result_valid` cycle: a second result follows 6 cycles later.

Source files
------------

// File: rtl/dot_product_engine_if.sv
// Operand-FIFO, control and result signals for dot_product_engine.
// The master side is the environment; the slave side is the engine.
interface dot_product_engine_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int RESULT_WIDTH = 16
);
    logic                    start;
    logic                    fifo_a_empty;
    logic [DATA_WIDTH-1:0]   fifo_a_dout;
    logic                    fifo_a_rd_en;
    logic                    fifo_b_empty;
    logic [DATA_WIDTH-1:0]   fifo_b_dout;
    logic                    fifo_b_rd_en;
    logic                    busy;
    logic [RESULT_WIDTH-1:0] dot_product_result;
    logic                    result_valid;

    modport master (
        output start,
        output fifo_a_empty,
        output fifo_a_dout,
        input  fifo_a_rd_en,
        output fifo_b_empty,
        output fifo_b_dout,
        input  fifo_b_rd_en,
        input  busy,
        input  dot_product_result,
        input  result_valid
    );

    modport slave (
        input  start,
        input  fifo_a_empty,
        input  fifo_a_dout,
        output fifo_a_rd_en,
        input  fifo_b_empty,
        input  fifo_b_dout,
        output fifo_b_rd_en,
        output busy,
        output dot_product_result,
        output result_valid
    );
endinterface

// File: rtl/dot_product_engine.sv
// Streaming signed multiply-accumulate over VEC_LEN operand pairs popped from two
// FIFOs; the full-precision sum is saturated to RESULT_WIDTH and strobed out.
module dot_product_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int VEC_LEN      = 4,
    parameter int RESULT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dot_product_engine_if.slave  bus
);
    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(VEC_LEN) + 1;
    localparam int CNT_WIDTH = $clog2(VEC_LEN + 1);
    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0]           issued_q, issued_d;
    logic [CNT_WIDTH-1:0]           accum_q, accum_d;
    logic                           dvalid_q, dvalid_d;
    logic [RESULT_WIDTH-1:0]        result_q, result_d;
    logic                           result_valid_q, result_valid_d;

    logic                           rd_en;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic                           last_elem;

    function automatic logic [RESULT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[RESULT_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[RESULT_WIDTH-1:0];
        else
            return v[RESULT_WIDTH-1:0];
    endfunction

    // Both FIFOs pop in lockstep, and only while reads remain outstanding.
    assign rd_en = (state_q == RUN) && !bus.fifo_a_empty && !bus.fifo_b_empty
                   && (issued_q < CNT_WIDTH'(VEC_LEN));

    assign product   = $signed(bus.fifo_a_dout) * $signed(bus.fifo_b_dout);
    assign acc_sum   = acc_q + {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    assign last_elem = dvalid_q && (accum_q == CNT_WIDTH'(VEC_LEN - 1));

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        issued_d       = issued_q;
        accum_d        = accum_q;
        dvalid_d       = rd_en;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    issued_d = '0;
                    accum_d  = '0;
                end
            end
            RUN: begin
                if (rd_en)
                    issued_d = issued_q + 1'b1;
                // Read data arrives the cycle after the pop, so issue and accumulate overlap.
                if (dvalid_q) begin
                    acc_d   = acc_sum;
                    accum_d = accum_q + 1'b1;
                end
                if (last_elem) begin
                    result_d       = saturate(acc_sum);
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            issued_q       <= '0;
            accum_q        <= '0;
            dvalid_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            issued_q       <= issued_d;
            accum_q        <= accum_d;
            dvalid_q       <= dvalid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.fifo_a_rd_en       = rd_en;
    assign bus.fifo_b_rd_en       = rd_en;
    assign bus.busy               = (state_q != IDLE);
    assign bus.dot_product_result = result_q;
    assign bus.result_valid       = result_valid_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Randomized and directed checks of dot_product_engine against an arithmetic
// reference, with a queue-based FIFO model that can inject stalls on operand B.
module tb_dot_product_engine;
    localparam int DW = 16;
    localparam int VL = 4;
    localparam int RW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_product_engine_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

    dot_product_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL), .RESULT_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int pops_a = 0, pops_b = 0;
    int stall_after = 0, stall_left = 0;

    // FIFO model: data appears the cycle after a pop; B can be held empty after a given pop count.
    always @(posedge clk) begin
        if (bus.fifo_a_rd_en) begin
            if (qa.size() > 0) bus.fifo_a_dout <= qa.pop_front();
            pops_a++;
        end
        if (bus.fifo_b_rd_en) begin
            if (qb.size() > 0) bus.fifo_b_dout <= qb.pop_front();
            pops_b++;
        end
        bus.fifo_a_empty <= (qa.size() == 0);
        if (qb.size() == 0)
            bus.fifo_b_empty <= 1'b1;
        else if (pops_b == stall_after && stall_left > 0) begin
            bus.fifo_b_empty <= 1'b1;
            stall_left--;
        end else
            bus.fifo_b_empty <= 1'b0;
    end

    function automatic logic [RW-1:0] ref_dot(input int av[$], input int bv[$]);
        longint s = 0;
        longint mx = (longint'(1) <<< (RW-1)) - 1;
        longint mn = -(longint'(1) <<< (RW-1));
        foreach (av[i]) s += longint'(av[i]) * longint'(bv[i]);
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return RW'(s);
    endfunction

    function automatic int rand_elem();
        case ($urandom_range(0, 3))
            0: return 32767;
            1: return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Drives one run from a start pulse in cycle 0 and records what the engine did over ncyc cycles.
    task automatic run_dot(input int av[$], input int bv[$], input int s_after, input int s_cyc,
                           input int restart, input int ncyc,
                           output int vcnt, output int vcyc0, output logic [RW-1:0] vres0,
                           output int vcyc1, output logic [RW-1:0] vres1, output int viol);
        @(negedge clk);
        qa.delete();
        qb.delete();
        foreach (av[i]) qa.push_back(DW'(av[i]));
        foreach (bv[i]) qb.push_back(DW'(bv[i]));
        pops_a = 0; pops_b = 0;
        stall_after = s_after; stall_left = s_cyc;
        @(negedge clk);
        bus.start = 1'b1;
        vcnt = 0; viol = 0; vcyc0 = -1; vcyc1 = -1; vres0 = 'x; vres1 = 'x;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus.start = (c == restart);
            if (bus.result_valid === 1'b1) begin
                if (vcnt == 0) begin vcyc0 = c; vres0 = bus.dot_product_result; end
                else if (vcnt == 1) begin vcyc1 = c; vres1 = bus.dot_product_result; end
                vcnt++;
            end
            if (bus.fifo_a_rd_en !== bus.fifo_b_rd_en) viol++;
            if (bus.fifo_a_rd_en === 1'b1 && (bus.fifo_a_empty || bus.fifo_b_empty)) viol++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.fifo_a_rd_en !== 1'b0 || bus.fifo_b_rd_en !== 1'b0) begin fails++;
            $display("FAIL reset_rd_en: got a=%b b=%b want 0", bus.fifo_a_rd_en, bus.fifo_b_rd_en); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
        tests++; if (bus.dot_product_result !== '0) begin fails++; $display("FAIL reset_result: got %h want 0", bus.dot_product_result); end
        rst = 1'b0;
        $display("[TB] reset: rd_en=%b busy=%b valid=%b result=%h", bus.fifo_a_rd_en, bus.busy, bus.result_valid, bus.dot_product_result);
    endtask

    task automatic test_fixed(input string name, input int av[$], input int bv[$], input logic [RW-1:0] want);
        int vcnt, c0, c1, viol;
        logic [RW-1:0] r0, r1;
        run_dot(av, bv, 0, 0, -1, 12, vcnt, c0, r0, c1, r1, viol);
        tests++; if (r0 !== want) begin fails++; $display("FAIL %s_result: got %h want %h", name, r0, want); end
        tests++; if (c0 != VL + 2) begin fails++; $display("FAIL %s_latency: got cycle %0d want %0d", name, c0, VL + 2); end
        tests++; if (vcnt != 1) begin fails++; $display("FAIL %s_strobes: got %0d want 1", name, vcnt); end
        tests++; if (pops_a != VL || pops_b != VL || viol != 0) begin fails++;
            $display("FAIL %s_pops: got a=%0d b=%0d viol=%0d want %0d %0d 0", name, pops_a, pops_b, viol, VL, VL); end
        $display("[TB] %s: result=%h cycle=%0d strobes=%0d pops=%0d/%0d", name, r0, c0, vcnt, pops_a, pops_b);
    endtask

    task automatic test_stall();
        int vcnt, c0, c1, viol;
        logic [RW-1:0] r0, r1;
        run_dot('{1, 2, 3, 4}, '{5, 6, 7, 8}, 2, 3, -1, 14, vcnt, c0, r0, c1, r1, viol);
        tests++; if (r0 !== 16'd70) begin fails++; $display("FAIL stall_result: got %h want 0046", r0); end
        tests++; if (c0 != 9) begin fails++; $display("FAIL stall_latency: got cycle %0d want 9", c0); end
        tests++; if (viol != 0 || pops_b != VL) begin fails++;
            $display("FAIL stall_rd_en: got viol=%0d pops_b=%0d want 0 %0d", viol, pops_b, VL); end
        $display("[TB] stall: result=%h cycle=%0d viol=%0d", r0, c0, viol);
    endtask

    task automatic test_random();
        int av[$], bv[$];
        int vcnt, c0, c1, viol, sa, sc;
        logic [RW-1:0] r0, r1, want;
        for (int n = 0; n < 16; n++) begin
            av.delete(); bv.delete();
            for (int i = 0; i < VL; i++) begin av.push_back(rand_elem()); bv.push_back(rand_elem()); end
            sa = int'($urandom_range(1, VL - 1));
            sc = int'($urandom_range(0, 3));
            want = ref_dot(av, bv);
            run_dot(av, bv, sa, sc, -1, 16, vcnt, c0, r0, c1, r1, viol);
            tests++; if (r0 !== want || c0 != VL + 2 + sc || vcnt != 1 || viol != 0) begin fails++;
                $display("FAIL random_%0d: got result=%h cycle=%0d strobes=%0d viol=%0d want %h %0d 1 0",
                         n, r0, c0, vcnt, viol, want, VL + 2 + sc); end
            $display("[TB] random %0d: stall %0d@%0d result=%h want=%h cycle=%0d", n, sc, sa, r0, want, c0);
        end
    endtask

    task automatic test_reset_mid();
        int av[$], bv[$];
        int vcnt, c0, c1, viol;
        logic [RW-1:0] r0, r1, want;
        @(negedge clk);
        qa.delete(); qb.delete();
        for (int i = 0; i < VL; i++) begin qa.push_back(DW'(i + 9)); qb.push_back(DW'(i + 3)); end
        stall_after = 0; stall_left = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bus.busy !== 1'b0 || bus.fifo_a_rd_en !== 1'b0 || bus.fifo_b_rd_en !== 1'b0 ||
                     bus.result_valid !== 1'b0 || bus.dot_product_result !== '0) begin fails++;
            $display("FAIL midreset_outputs: got busy=%b rd=%b/%b valid=%b result=%h want all 0",
                     bus.busy, bus.fifo_a_rd_en, bus.fifo_b_rd_en, bus.result_valid, bus.dot_product_result); end
        for (int i = 0; i < VL; i++) begin av.push_back(rand_elem()); bv.push_back(rand_elem()); end
        want = ref_dot(av, bv);
        run_dot(av, bv, 0, 0, -1, 12, vcnt, c0, r0, c1, r1, viol);
        tests++; if (r0 !== want || c0 != VL + 2 || vcnt != 1) begin fails++;
            $display("FAIL midreset_rerun: got result=%h cycle=%0d strobes=%0d want %h %0d 1", r0, c0, vcnt, want, VL + 2); end
        $display("[TB] reset mid-run: rerun result=%h want=%h cycle=%0d", r0, want, c0);
    endtask

    task automatic test_start_while_busy();
        int av[$], bv[$];
        int vcnt, c0, c1, viol;
        logic [RW-1:0] r0, r1, want;
        for (int i = 0; i < 2*VL; i++) begin av.push_back(rand_elem()); bv.push_back(rand_elem()); end
        want = ref_dot(av[0:VL-1], bv[0:VL-1]);
        run_dot(av, bv, 0, 0, 2, 20, vcnt, c0, r0, c1, r1, viol);
        tests++; if (vcnt != 1 || r0 !== want || c0 != VL + 2 || pops_a != VL) begin fails++;
            $display("FAIL busy_start: got strobes=%0d result=%h cycle=%0d pops=%0d want 1 %h %0d %0d",
                     vcnt, r0, c0, pops_a, want, VL + 2, VL); end
        $display("[TB] start while busy: strobes=%0d result=%h pops=%0d", vcnt, r0, pops_a);
    endtask

    task automatic test_back_to_back();
        int av[$], bv[$];
        int vcnt, c0, c1, viol;
        logic [RW-1:0] r0, r1, want0, want1;
        for (int i = 0; i < 2*VL; i++) begin av.push_back(rand_elem()); bv.push_back(rand_elem()); end
        want0 = ref_dot(av[0:VL-1], bv[0:VL-1]);
        want1 = ref_dot(av[VL:2*VL-1], bv[VL:2*VL-1]);
        run_dot(av, bv, 0, 0, VL + 2, 20, vcnt, c0, r0, c1, r1, viol);
        tests++; if (vcnt != 2 || c0 != VL + 2 || c1 != 2*(VL + 2)) begin fails++;
            $display("FAIL b2b_timing: got strobes=%0d cycles=%0d,%0d want 2 %0d,%0d", vcnt, c0, c1, VL + 2, 2*(VL + 2)); end
        tests++; if (r0 !== want0 || r1 !== want1) begin fails++;
            $display("FAIL b2b_results: got %h,%h want %h,%h", r0, r1, want0, want1); end
        $display("[TB] back-to-back: results=%h,%h cycles=%0d,%0d", r0, r1, c0, c1);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.fifo_a_empty = 1'b1;
        bus.fifo_b_empty = 1'b1;
        bus.fifo_a_dout  = '0;
        bus.fifo_b_dout  = '0;
        test_reset();
        test_fixed("basic",   '{1, 2, 3, 4},     '{5, 6, 7, 8},     16'd70);
        test_fixed("signed",  '{-3, 2, -1, 4},   '{5, -6, 7, 8},    16'hFFFE);
        test_fixed("sat_pos", '{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}, 16'h7FFF);
        test_fixed("sat_neg", '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 16'h8000);
        test_stall();
        test_random();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
